// File: rtl/md5_in_packer.sv
// md5_in_packer: packs 32-bit message words into 128-bit blocks through a 2-entry FIFO
// s_data/s_valid/s_ready : upstream word stream; flush drops a partly assembled block
// m_data/m_valid/m_ready : block stream to the hash core; first word lands in m_data[31:0]
// blk_cnt                : wrapping count of blocks taken by the core
module md5_in_packer #(
  parameter bit BYTE_SWAP  = 1'b0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         flush,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [15:0]  blk_cnt
);
  logic [1:0]   wcnt_q, wcnt_d, cnt_q, cnt_d;
  logic [95:0]  asm_q, asm_d;
  logic [127:0] f0_q, f0_d, f1_q, f1_d, blk;
  logic [15:0]  blk_cnt_q, blk_cnt_d;
  logic [31:0]  word;
  logic         wr, push, pop;
  assign word    = BYTE_SWAP ? {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]} : s_data;
  assign s_ready = cnt_q < 2'(FIFO_DEPTH);
  assign m_valid = cnt_q != 2'd0;
  // f0 may hold a stale block after the last pop, so mask it when empty
  assign m_data  = m_valid ? f0_q : 128'd0;
  assign blk_cnt = blk_cnt_q;
  assign wr      = s_valid && s_ready;
  assign push    = wr && !flush && wcnt_q == 2'd3;
  assign pop     = m_valid && m_ready;
  // words shift in from the top, so after three words asm_q = {w2, w1, w0}
  assign blk     = {word, asm_q};
  always_comb begin
    wcnt_d    = flush ? 2'd0 : wr ? wcnt_q + 2'd1 : wcnt_q;
    asm_d     = (wr && !flush) ? {word, asm_q[95:32]} : asm_q;
    f0_d      = pop ? ((push && cnt_q == 2'd1) ? blk : f1_q) : ((push && cnt_q == 2'd0) ? blk : f0_q);
    f1_d      = (push && (pop ? cnt_q == 2'd2 : cnt_q != 2'd0)) ? blk : f1_q;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    blk_cnt_d = pop ? blk_cnt_q + 16'd1 : blk_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      asm_q     <= '0;
      cnt_q     <= '0;
      f0_q      <= '0;
      f1_q      <= '0;
      blk_cnt_q <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      f0_q      <= f0_d;
      f1_q      <= f1_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end
endmodule

// File: tb/tb_md5_in_packer.sv
// tb_md5_in_packer: directed and random checks of md5_in_packer against a queue-based model
module tb_md5_in_packer;
  logic         clk = 1'b0;
  logic         rst, s_valid, flush, m_ready;
  logic [31:0]  s_data;
  logic         s_ready, m_valid, s_ready_s, m_valid_s;
  logic [127:0] m_data, m_data_s;
  logic [15:0]  blk_cnt, blk_cnt_s;
  int           checks = 0, failures = 0;
  logic [31:0]  part[$];
  logic [127:0] q[$], qs[$];
  logic [15:0]  mblk = 16'd0;
  logic         acc;
  logic [31:0]  w;
  int           budget;

  always #5 clk = ~clk;

  md5_in_packer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .blk_cnt(blk_cnt)
  );
  md5_in_packer #(.BYTE_SWAP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s), .flush(flush),
    .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready), .blk_cnt(blk_cnt_s)
  );

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("s_ready", {127'd0, s_ready}, {127'd0, q.size() < 2});
    chk("m_valid", {127'd0, m_valid}, {127'd0, q.size() != 0});
    chk("m_data", m_data, q.size() != 0 ? q[0] : 128'd0);
    chk("blk_cnt", {112'd0, blk_cnt}, {112'd0, mblk});
    chk("m_data_swap", m_data_s, qs.size() != 0 ? qs[0] : 128'd0);
    chk("blk_cnt_swap", {112'd0, blk_cnt_s}, {112'd0, mblk});
  endtask

  // one clock: apply inputs, advance the model by the transfer rules, then compare
  task automatic cyc(input logic v, input logic [31:0] d, input logic fl, input logic mr, input logic r, output logic accepted);
    logic sr;
    s_valid = v; s_data = d; flush = fl; m_ready = mr; rst = r;
    sr = q.size() < 2;
    accepted = !r && v && sr && !fl;
    @(posedge clk);
    if (r) begin
      part.delete(); q.delete(); qs.delete(); mblk = 16'd0;
    end else begin
      if (q.size() != 0 && mr) begin
        void'(q.pop_front()); void'(qs.pop_front()); mblk++;
      end
      if (fl) part.delete();
      else if (v && sr) begin
        part.push_back(d);
        if (part.size() == 4) begin
          q.push_back({part[3], part[2], part[1], part[0]});
          qs.push_back({bswap(part[3]), bswap(part[2]), bswap(part[1]), bswap(part[0])});
          part.delete();
        end
      end
    end
    #1;
    check_all();
  endtask

  // offer one word until accepted, bounded
  task automatic send(input logic [31:0] d, input logic mr);
    logic a;
    budget = 0;
    do begin
      cyc(1'b1, d, 1'b0, mr, 1'b0, a);
      budget++;
    end while (!a && budget < 20);
    chk("send_timeout", {127'd0, a}, 128'd1);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b0, mr, 1'b0, acc);
  endtask

  initial begin
    s_valid = 0; s_data = 0; flush = 0; m_ready = 0; rst = 1;
    #1;
    cyc(0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 1, acc);
    chk("reset_m_data", m_data, 128'd0);
    idle(1, 1);
    send(32'h11111111, 1); send(32'h22222222, 1); send(32'h33333333, 1); send(32'h44444444, 1);
    chk("basic_block", m_data, 128'h44444444_33333333_22222222_11111111);
    idle(1, 1);
    chk("basic_cnt", {112'd0, blk_cnt}, 128'd1);
    send(32'hAABBCCDD, 1); send(32'h01020304, 1); send(32'h05060708, 1); send(32'h090A0B0C, 0);
    chk("swap_slot0", {96'd0, m_data_s[31:0]}, {96'd0, 32'hDDCCBBAA});
    idle(2, 1);
    for (int i = 1; i <= 8; i++) send(32'h100 + i, 0);
    chk("full_s_ready", {127'd0, s_ready}, 128'd0);
    cyc(1, 32'h109, 0, 0, 0, acc);
    cyc(1, 32'h109, 0, 0, 0, acc);
    chk("full_hold", m_data, 128'h00000104_00000103_00000102_00000101);
    for (int i = 9; i <= 12; i++) send(32'h100 + i, 1);
    idle(4, 1);
    send(32'hDEAD0001, 1); send(32'hDEAD0002, 1);
    cyc(0, 0, 1, 1, 0, acc);
    for (int i = 1; i <= 4; i++) send(i, 1);
    chk("flush_block", m_data, 128'h00000004_00000003_00000002_00000001);
    idle(2, 1);
    send(32'hBEEF0001, 1); send(32'hBEEF0002, 1); send(32'hBEEF0003, 1);
    cyc(1, 32'hBEEF0004, 1, 1, 0, acc);
    idle(2, 1);
    for (int i = 0; i < 4; i++) send(32'hCAFE0000 + i, 0);
    send(32'h5A5A0001, 0); send(32'h5A5A0002, 0); send(32'h5A5A0003, 0);
    cyc(1, 32'h5A5A0004, 1, 1, 1, acc);
    chk("rst_m_valid", {127'd0, m_valid}, 128'd0);
    for (int i = 0; i < 4; i++) send(32'h77770000 + i, 1);
    idle(2, 1);
    dut.blk_cnt_q = 16'hFFFE;
    dut_s.blk_cnt_q = 16'hFFFE;
    mblk = 16'hFFFE;
    for (int i = 0; i < 8; i++) send(32'h88880000 + i, 0);
    for (int i = 0; i < 4; i++) send(32'h99990000 + i, 1);
    chk("wrap_valid", {127'd0, m_valid}, 128'd1);
    idle(4, 1);
    chk("wrap_cnt", {112'd0, blk_cnt}, 128'd1);
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      cyc(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) == 0), acc);
    end
    idle(4, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md5_in_packer.md
MD5_IN_PACKER -- requirements
Module: md5_in_packer

Interface
REQ-001 Parameter BYTE_SWAP, default 0: when 1, each input word is byte-reversed before packing.
REQ-002 Parameter FIFO_DEPTH, fixed 2: number of 128-bit block entries; no other value is supported.
REQ-003 Reset is rst, synchronous, active-high; the clock is clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s_data  input  32  upstream message word.
REQ-007 s_valid  input  1  s_data is valid.
REQ-008 s_ready  output  1  block can accept a word.
REQ-009 flush  input  1  discard any partially assembled block.
REQ-010 m_data  output  128  packed block, connects to the hash core's 128-bit input.
REQ-011 m_valid  output  1  m_data is valid, connects to the core's in_valid.
REQ-012 m_ready  input  1  core is idle and will take the block, connects to the core's ready.
REQ-013 blk_cnt  output  16  number of blocks delivered downstream.

Function
REQ-014 Word transfer occurs on a rising edge with s_valid && s_ready; block transfer occurs on a rising edge with m_valid && m_ready.
REQ-015 Word k (k = 0..3) of a block is placed in m_data[32k+31:32k], so the first word accepted lands in bits [31:0].
REQ-016 With BYTE_SWAP=1, the stored word is {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]}; with BYTE_SWAP=0 it is s_data unchanged.
REQ-017 A 2-bit word counter tracks assembly progress: it increments on each word transfer and wraps 3 -> 0.
REQ-018 When the word counter wraps, the completed 128-bit block is pushed into the FIFO on that same edge.
REQ-019 s_ready is 1 exactly when the FIFO holds fewer than 2 entries; it is a function of registered state only, with no combinational path from m_ready.
REQ-020 m_valid is 1 exactly when the FIFO is non-empty; m_data is the FIFO head and is 0 when the FIFO is empty.
REQ-021 Latency: the 4th word is accepted at edge N; m_valid is 1 in the cycle after edge N.
REQ-022 m_data and m_valid hold stable while m_valid && !m_ready.
REQ-023 Push and pop on the same edge leave the FIFO count unchanged; the new block enters behind the popped head.
REQ-024 Pop with no push decrements the count; push with no pop increments the count; pop on an empty FIFO or push on a full FIFO cannot occur by construction.
REQ-025 blk_cnt increments by 1 on each block transfer and wraps 0xFFFF -> 0x0000.
REQ-026 Flush has priority over a simultaneous word transfer: the word counter clears to 0 and the word offered in that cycle is discarded.
REQ-027 Flush does not alter FIFO contents, m_valid, or blk_cnt.
REQ-028 Flush in the same cycle as a 4th word: the block is not pushed and the word counter is 0.

Reset
REQ-029 On rst: word counter = 0, assembly register = 0, FIFO count = 0, all FIFO entries = 0, blk_cnt = 0.
REQ-030 Output values in the cycle after a reset edge: s_ready = 1, m_valid = 0, m_data = 0.
REQ-031 rst asserted mid-assembly or with blocks queued discards all partial and queued data; no block is emitted afterwards.
REQ-032 rst has priority over flush and over any handshake in the same cycle.

Verification
REQ-033 Scenario: BYTE_SWAP=0, m_ready=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles -> m_data = 0x44444444_33333333_22222222_11111111 with m_valid for 1 cycle, then blk_cnt = 1.
REQ-034 Scenario: BYTE_SWAP=1, word 0xAABBCCDD in slot 0 -> m_data[31:0] = 0xDDCCBBAA.
REQ-035 Scenario: m_ready held 0 while 12 words are offered -> s_ready drops to 0 after the 8th word; the 9th word stalls; m_data holds block 0; after m_ready=1 the blocks emerge in order 0, 1, 2.
REQ-036 Scenario: 2 words, then flush, then 4 words 0x1..0x4 -> one block 0x00000004_00000003_00000002_00000001 is emitted; the earlier words are absent from all blocks.
REQ-037 Scenario: rst after 3 words with 1 block queued -> m_valid = 0, blk_cnt = 0; the next 4 words form a fresh block.
REQ-038 Scenario: blk_cnt preloaded near wrap by 65536 transfers -> it wraps to 0; a pop and a push on the same edge keep m_valid = 1 with the correct order preserved.
